retire_trace_buffer: RTL and testbench

// - Receive side of the core's retire-trace port (update/pc/instr/reg/mem signals); sits beside the core in the SoC/bench top.
// - Samples one retire record per cycle with update_i=1, tags it with a sequence number, and buffers it in a FIFO.
// - Drains records over a valid/ready stream to a logger/UART/checker; counts records lost on overflow.

---
 rtl/retire_trace_buffer_pkg.sv | 29 ++
 rtl/retire_trace_buffer_trace_fifo.sv | 65 ++++++
 rtl/retire_trace_buffer.sv | 127 ++++++++++++
 tb/tb_retire_trace_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire-trace buffer: record layout, capture states, widths.
// The record gains a 32-bit ts field when TRACE_TIMESTAMP_EN is defined.
package retire_trace_buffer_pkg;

    localparam int XLEN        = 32;
    localparam int TRACE_SEQ_W = 16;
    localparam int TRACE_TS_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        instr;
        logic [4:0]             rd;
        logic [XLEN-1:0]        rd_data;
        logic [XLEN-1:0]        mem_addr;
        logic [XLEN-1:0]        mem_data;
        logic                   mem_wrt;
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0]  ts;
`endif
    } trace_rec_t;

endpackage

// File: rtl/retire_trace_buffer_trace_fifo.sv
// Generic synchronous FIFO with a registered head output; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level_o = r_wr_ptr - r_rd_ptr;
    assign dout_o  = r_dout;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_pop     = pop_i && !empty_o;
    assign w_push    = push_i && (!full_o || w_pop);
    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // NOTE: the storage array has no reset; only pointers and the head register do,
    // so the array maps onto plain RAM and stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            // Preload the next head; if its slot is being written now, take din directly.
            if (w_rd_next != w_wr_next) begin
                r_dout <= (w_rd_next == r_wr_ptr) ? din_i : r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-trace receiver: tags retire records with a sequence number, buffers them and
// drains them over valid/ready. Define TRACE_TIMESTAMP_EN to add a cycle timestamp.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      arm_i,
    input  logic                      stop_i,
    input  logic                      update_i,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [XLEN-1:0]           instr_i,
    input  logic [4:0]                reg_addr_i,
    input  logic [XLEN-1:0]           reg_data_i,
    input  logic [XLEN-1:0]           mem_addr_i,
    input  logic [XLEN-1:0]           mem_data_i,
    input  logic                      mem_wrt_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output trace_rec_t                trace_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [15:0]               drop_cnt_o,
    output logic [1:0]                state_o
);

    localparam int REC_W = $bits(trace_rec_t);

    trace_state_e           r_state;
    trace_state_e           w_state_next;
    logic [TRACE_SEQ_W-1:0] r_seq;
    logic [15:0]            r_drop_cnt;
    trace_rec_t             w_rec;
    logic [REC_W-1:0]       w_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push_try;
    logic                   w_pop;
    logic                   w_drop;

`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_TS_W-1:0]  r_ts;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end
`endif

    assign w_push_try = (r_state == CAPTURE) && update_i;
    assign w_pop      = trace_valid_o && trace_ready_i;
    assign w_drop     = w_push_try && w_full && !w_pop;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_rec          = '0;
        w_rec.seq      = r_seq;
        w_rec.pc       = pc_i;
        w_rec.instr    = instr_i;
        w_rec.rd       = reg_addr_i;
        w_rec.rd_data  = reg_data_i;
        w_rec.mem_addr = mem_addr_i;
        w_rec.mem_data = mem_data_i;
        w_rec.mem_wrt  = mem_wrt_i;
`ifdef TRACE_TIMESTAMP_EN
        w_rec.ts       = r_ts;
`endif
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push_try),
        .pop_i   (w_pop),
        .din_i   (w_rec),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    // stop wins over arm; a lost record only halts capture when STOP_ON_FULL is set.
    always_comb begin
        w_state_next = r_state;
        if (stop_i) begin
            w_state_next = IDLE;
        end else if (arm_i) begin
            w_state_next = CAPTURE;
        end else if ((r_state == CAPTURE) && w_drop && (STOP_ON_FULL != 0)) begin
            w_state_next = HALTED;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Sequence advances on every attempt so gaps reveal dropped records.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seq      <= '0;
            r_drop_cnt <= '0;
        end else if (arm_i) begin
            r_seq      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_try) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign trace_valid_o = !w_empty;
    assign trace_o       = trace_rec_t'(w_dout);
    assign drop_cnt_o    = r_drop_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: one instance drops on overflow, one halts.
// A negedge scoreboard predicts every drained record of the drop-on-overflow instance.
module tb_retire_trace_buffer;
    import retire_trace_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst, arm, stop, update, ready, mwrt;
    logic [31:0] pc, instr, rd_data, maddr, mdata;
    logic [4:0]  rd;

    logic          d0_valid, d1_valid;
    trace_rec_t    d0_trace, d1_trace;
    logic [LW-1:0] d0_level, d1_level;
    logic [15:0]   d0_drop, d1_drop;
    logic [1:0]    d0_state, d1_state;

    int n_checks = 0;
    int n_errors = 0;
    trace_rec_t exp_q[$];

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_i(stop), .update_i(update),
        .pc_i(pc), .instr_i(instr), .reg_addr_i(rd), .reg_data_i(rd_data),
        .mem_addr_i(maddr), .mem_data_i(mdata), .mem_wrt_i(mwrt),
        .trace_valid_o(d0_valid), .trace_ready_i(ready), .trace_o(d0_trace),
        .level_o(d0_level), .drop_cnt_o(d0_drop), .state_o(d0_state)
    );

    retire_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_i(stop), .update_i(update),
        .pc_i(pc), .instr_i(instr), .reg_addr_i(rd), .reg_data_i(rd_data),
        .mem_addr_i(maddr), .mem_data_i(mdata), .mem_wrt_i(mwrt),
        .trace_valid_o(d1_valid), .trace_ready_i(ready), .trace_o(d1_trace),
        .level_o(d1_level), .drop_cnt_o(d1_drop), .state_o(d1_state)
    );

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic push_full(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] r,
                             input logic [31:0] rdd, input logic [31:0] ma, input logic [31:0] md,
                             input logic mw);
        pc = p; instr = ins; rd = r; rd_data = rdd; maddr = ma; mdata = md; mwrt = mw;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic push_pc(input logic [31:0] p);
        push_full(p, p ^ 32'h0000_0013, p[6:2], ~p, p + 32'h1000, p * 3, p[2]);
    endtask

    // Scoreboard model of the drop-on-overflow instance, evaluated between edges.
    trace_state_e m_state;
    int           m_level;
    logic [15:0]  m_seq;
    logic [15:0]  m_drop;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]  m_ts;
`endif

    always @(negedge clk) begin
        trace_rec_t exp_rec;
        logic       pop;
        logic       attempt;
        logic       acc;
        if (rst) begin
            m_state = IDLE;
            m_level = 0;
            m_seq   = '0;
            m_drop  = '0;
            exp_q.delete();
`ifdef TRACE_TIMESTAMP_EN
            m_ts    = '0;
`endif
        end else begin
            check("sb_valid", d0_valid, m_level != 0);
            check("sb_level", d0_level, m_level);
            check("sb_drop", d0_drop, m_drop);
            pop = (m_level != 0) && ready;
            if (pop) begin
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_rec = exp_q.pop_front();
                    check("sb_record", d0_trace, exp_rec);
                end
            end
            attempt = (m_state == CAPTURE) && update;
            acc     = attempt && ((m_level < DEPTH) || pop);
            if (acc) begin
                exp_rec          = '0;
                exp_rec.seq      = m_seq;
                exp_rec.pc       = pc;
                exp_rec.instr    = instr;
                exp_rec.rd       = rd;
                exp_rec.rd_data  = rd_data;
                exp_rec.mem_addr = maddr;
                exp_rec.mem_data = mdata;
                exp_rec.mem_wrt  = mwrt;
`ifdef TRACE_TIMESTAMP_EN
                exp_rec.ts       = m_ts;
`endif
                exp_q.push_back(exp_rec);
            end
            m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (attempt && !acc && (m_drop != 16'hFFFF)) m_drop++;
            if (attempt) m_seq++;
            if (arm) begin
                m_seq  = '0;
                m_drop = '0;
            end
            if (stop)     m_state = IDLE;
            else if (arm) m_state = CAPTURE;
`ifdef TRACE_TIMESTAMP_EN
            m_ts++;
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; update = 1'b0; ready = 1'b0;
        pc = '0; instr = '0; rd = '0; rd_data = '0; maddr = '0; mdata = '0; mwrt = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset values
        check("rst_valid", d0_valid, 1'b0);
        check("rst_level", d0_level, 0);
        check("rst_drop", d0_drop, 0);
        check("rst_state", d0_state, IDLE);
        check("rst_trace", d0_trace, '0);
        check("rst_state1", d1_state, IDLE);

        // Three records drained as they arrive
        ready = 1'b1;
        pulse_arm();
        check("arm_state", d0_state, CAPTURE);
        push_pc(32'h0);
        check("t1_latency_valid", d0_valid, 1'b1);
        check("t1_first_seq", d0_trace.seq, 16'd0);
        push_pc(32'h4);
        push_pc(32'h8);
        repeat (2) tick();
        check("t1_level_empty", d0_level, 0);
        check("t1_valid_low", d0_valid, 1'b0);

        // Overflow with drop counting
        ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 20; i++) push_pc(32'h100 + 32'(4 * i));
        check("ovf_level", d0_level, DEPTH);
        check("ovf_drop", d0_drop, 16'd4);
        check("ovf_head_seq", d0_trace.seq, 16'd0);
        ready = 1'b1;
        repeat (17) tick();
        check("ovf_drained", d0_level, 0);
        push_pc(32'h2000);
        check("ovf_next_seq", d0_trace.seq, 16'd20);
        repeat (2) tick();

        // Push and pop together on a full FIFO, then hold the head
        ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 16; i++) push_pc(32'h3000 + 32'(4 * i));
        check("full_level", d0_level, DEPTH);
        ready = 1'b1;
        push_pc(32'h3040);
        ready = 1'b0;
        check("full_pushpop_level", d0_level, DEPTH);
        check("full_pushpop_drop", d0_drop, 16'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_seq", d0_trace.seq, 16'd1);
            check("hold_pc", d0_trace.pc, 32'h3004);
            tick();
        end
        ready = 1'b1;
        repeat (17) tick();

        // Memory-write record fields reproduced exactly
        push_full(32'h4000, 32'h00A5_A023, 5'd0, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b1);
        check("mem_wrt", d0_trace.mem_wrt, 1'b1);
        check("mem_addr", d0_trace.mem_addr, 32'h100);
        check("mem_data", d0_trace.mem_data, 32'hDEAD_BEEF);
        check("mem_pc", d0_trace.pc, 32'h4000);
        check("mem_seq", d0_trace.seq, 16'd17);
        repeat (2) tick();

        // Halt on overflow (STOP_ON_FULL=1 instance)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 17; i++) push_pc(32'h5000 + 32'(4 * i));
        check("halt_state", d1_state, HALTED);
        check("halt_drop", d1_drop, 16'd1);
        check("halt_level", d1_level, DEPTH);
        for (int i = 0; i < 3; i++) push_pc(32'h6000 + 32'(4 * i));
        check("halt_drop_frozen", d1_drop, 16'd1);
        check("halt_level_frozen", d1_level, DEPTH);
        check("halt_state_held", d1_state, HALTED);
        check("nohalt_drop", d0_drop, 16'd4);
        check("nohalt_state", d0_state, CAPTURE);
        pulse_arm();
        check("rearm_state", d1_state, CAPTURE);
        check("rearm_drop", d1_drop, 16'd0);
        ready = 1'b1;
        repeat (17) tick();
        check("halt_drained", d1_level, 0);

        // Reset mid-operation, then arm and stop together
        ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 7; i++) push_pc(32'h7000 + 32'(4 * i));
        check("mid_level", d0_level, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", d0_valid, 1'b0);
        check("mid_rst_level", d0_level, 0);
        check("mid_rst_state", d0_state, IDLE);
        check("mid_rst_level1", d1_level, 0);
        pulse_arm();
        check("rearm2_state", d0_state, CAPTURE);
        arm = 1'b1;
        stop = 1'b1;
        tick();
        arm = 1'b0;
        stop = 1'b0;
        check("armstop_state", d0_state, IDLE);
        check("armstop_state1", d1_state, IDLE);

        tick();
        check("sb_all_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
